atan_share_arbiter: RTL and testbench



---
 rtl/atan_share_arbiter_if.sv | 38 +++
 rtl/atan_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_atan_share_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/atan_share_arbiter_if.sv
// Bundle between the shared arctan arbiter and its clients/core: requester handshakes,
// core issue/return path, per-owner responses and occupancy status.
interface atan_share_arbiter_if #(
    parameter int N_REQ           = 4,
    parameter int DIN_WIDTH       = 32,
    parameter int DOUT_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int TOTAL_WIDTH = $clog2(N_REQ * MAX_OUTSTANDING + 1);

    logic [N_REQ*DIN_WIDTH-1:0] req_din1;
    logic [N_REQ*DIN_WIDTH-1:0] req_din2;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [DIN_WIDTH-1:0]       core_din1;
    logic [DIN_WIDTH-1:0]       core_din2;
    logic                       core_din_valid;
    logic [DOUT_WIDTH-1:0]      core_dout;
    logic                       core_dout_valid;
    logic [DOUT_WIDTH-1:0]      resp_dout;
    logic [N_REQ-1:0]           resp_valid;
    logic [TOTAL_WIDTH-1:0]     outstanding_total;
    logic                       err;

    // Arbiter side
    modport slave (
        input  req_din1, req_din2, req_valid, core_dout, core_dout_valid,
        output req_ready, core_din1, core_din2, core_din_valid,
               resp_dout, resp_valid, outstanding_total, err
    );

    // Client/core side
    modport master (
        output req_din1, req_din2, req_valid, core_dout, core_dout_valid,
        input  req_ready, core_din1, core_din2, core_din_valid,
               resp_dout, resp_valid, outstanding_total, err
    );
endinterface

// File: rtl/atan_share_arbiter.sv
// Round-robin sharing of one fixed-latency arctan pipeline: credit-limited per-requester
// issue, tag pipeline aligned to the core latency, one-hot result routing and error check.
module atan_share_arbiter #(
    parameter int N_REQ           = 4,
    parameter int DIN_WIDTH       = 32,
    parameter int DOUT_WIDTH      = 16,
    parameter int PIPE_LATENCY    = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    atan_share_arbiter_if.slave  bus_if
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW  = $clog2(N_REQ * MAX_OUTSTANDING + 1);
    localparam int BW  = $clog2(PIPE_LATENCY + 1);

    logic [CW-1:0]         cnt_q [N_REQ];
    logic [CW-1:0]         cnt_d [N_REQ];
    logic [DIN_WIDTH-1:0]  din1_arr [N_REQ];
    logic [DIN_WIDTH-1:0]  din2_arr [N_REQ];
    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      acc_oh;
    logic [N_REQ-1:0]      ret_oh;

    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW:0]          cand;
    logic                  grant_found;
    logic [IDW-1:0]        grant_idx;

    // Stage 0 shadows the issue register; stage PIPE_LATENCY lines up with core_dout_valid.
    logic [PIPE_LATENCY:0] tag_valid_q, tag_valid_d;
    logic [IDW-1:0]        tag_id_q [PIPE_LATENCY+1];
    logic                  last_valid;
    logic [IDW-1:0]        last_id;

    logic [DIN_WIDTH-1:0]  core_din1_q, core_din2_q;
    logic                  core_din_valid_q;
    logic [DOUT_WIDTH-1:0] resp_dout_q;
    logic [N_REQ-1:0]      resp_valid_q;
    logic [TW-1:0]         total_q, total_d;
    logic                  err_q;
    logic [BW-1:0]         blank_q;
    logic                  blanking;
    logic                  resp_fire;
    logic                  err_set;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign din1_arr[gi] = bus_if.req_din1[gi*DIN_WIDTH +: DIN_WIDTH];
            assign din2_arr[gi] = bus_if.req_din2[gi*DIN_WIDTH +: DIN_WIDTH];
            assign eligible[gi] = bus_if.req_valid[gi] && (cnt_q[gi] < CW'(MAX_OUTSTANDING));
            assign acc_oh[gi]   = grant_found && (grant_idx == IDW'(gi));
            assign ret_oh[gi]   = last_valid && (last_id == IDW'(gi));
            assign cnt_d[gi]    = (acc_oh[gi] && !ret_oh[gi]) ? cnt_q[gi] + 1'b1 :
                                  (!acc_oh[gi] && ret_oh[gi]) ? cnt_q[gi] - 1'b1 :
                                  cnt_q[gi];
        end
    endgenerate

    // Scan from rr_ptr upward, wrapping at N_REQ; first eligible index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!grant_found && eligible[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        total_d = total_q;
        if (grant_found && !last_valid) begin
            total_d = total_q + TW'(1);
        end else if (!grant_found && last_valid) begin
            total_d = total_q - TW'(1);
        end
    end

    assign tag_valid_d = {tag_valid_q[PIPE_LATENCY-1:0], grant_found};
    assign last_valid  = tag_valid_q[PIPE_LATENCY];
    assign last_id     = tag_id_q[PIPE_LATENCY];

    // The core is never reset, so its output is untrusted until the old contents have drained.
    assign blanking  = (blank_q != '0);
    assign resp_fire = last_valid && bus_if.core_dout_valid && !blanking;
    assign err_set   = !blanking && (last_valid != bus_if.core_dout_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q         <= '0;
            core_din1_q      <= '0;
            core_din2_q      <= '0;
            core_din_valid_q <= 1'b0;
            tag_valid_q      <= '0;
            resp_dout_q      <= '0;
            resp_valid_q     <= '0;
            total_q          <= '0;
            err_q            <= 1'b0;
            blank_q          <= BW'(PIPE_LATENCY);
            for (int k = 0; k <= PIPE_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            for (int k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            core_din_valid_q <= grant_found;
            if (grant_found) begin
                core_din1_q <= din1_arr[grant_idx];
                core_din2_q <= din2_arr[grant_idx];
            end
            tag_valid_q <= tag_valid_d;
            tag_id_q[0] <= grant_idx;
            for (int k = 1; k <= PIPE_LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            for (int k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            total_q      <= total_d;
            resp_valid_q <= resp_fire ? ret_oh : '0;
            if (resp_fire) begin
                resp_dout_q <= bus_if.core_dout;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (blanking) begin
                blank_q <= blank_q - 1'b1;
            end
        end
    end

    assign bus_if.req_ready         = rst ? '0 : acc_oh;
    assign bus_if.core_din1         = core_din1_q;
    assign bus_if.core_din2         = core_din2_q;
    assign bus_if.core_din_valid    = core_din_valid_q;
    assign bus_if.resp_dout         = resp_dout_q;
    assign bus_if.resp_valid        = resp_valid_q;
    assign bus_if.outstanding_total = total_q;
    assign bus_if.err               = err_q;
endmodule

// File: tb/tb_atan_share_arbiter.sv
// Bench for atan_share_arbiter: directed scenarios push expected responses into a
// scoreboard; a monitor pops and compares every resp_valid pulse, including its cycle.
module tb_atan_share_arbiter;
    localparam int N_REQ   = 4;
    localparam int DIN_W   = 32;
    localparam int DOUT_W  = 16;
    localparam int L       = 20;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    atan_share_arbiter_if #(
        .N_REQ(N_REQ), .DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .MAX_OUTSTANDING(MAX_OUT)
    ) bus_if ();

    atan_share_arbiter #(
        .N_REQ(N_REQ), .DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W),
        .PIPE_LATENCY(L), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [N_REQ-1:0] owner;
        logic [15:0]      dout;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Core stand-in: fixed-latency delay line, never reset. Equal operands give 0x2000
    // (45 degrees), otherwise it echoes din1[15:0]. 'late' adds one extra cycle.
    logic        late = 1'b0;
    logic        sh_v [0:L];
    logic [15:0] sh_d [0:L];
    always @(posedge clk) begin
        sh_v[0] <= bus_if.core_din_valid;
        sh_d[0] <= (bus_if.core_din1 == bus_if.core_din2) ? 16'h2000 : bus_if.core_din1[15:0];
        for (int k = 1; k <= L; k++) begin
            sh_v[k] <= sh_v[k-1];
            sh_d[k] <= sh_d[k-1];
        end
    end
    assign bus_if.core_dout_valid = late ? sh_v[L] : sh_v[L-1];
    assign bus_if.core_dout       = late ? sh_d[L] : sh_d[L-1];

    int dv_count = 0;
    always @(negedge clk) if (bus_if.core_dout_valid === 1'b1) dv_count <= dv_count + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (bus_if.resp_valid != '0) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got owner %b dout 0x%h at cycle %0d, expected none",
                         bus_if.resp_valid, bus_if.resp_dout, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || bus_if.resp_valid !== mon_e.owner || bus_if.resp_dout !== mon_e.dout) begin
                    fails++;
                    $display("FAIL resp: got owner %b dout 0x%h cycle %0d, expected owner %b dout 0x%h cycle %0d",
                             bus_if.resp_valid, bus_if.resp_dout, cyc, mon_e.owner, mon_e.dout, mon_e.cyc);
                end else begin
                    $display("resp owner=%b dout=0x%h cycle=%0d", bus_if.resp_valid, bus_if.resp_dout, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200us");
        $fatal(1);
    end

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        bus_if.req_din1[r*DIN_W +: DIN_W] = a;
        bus_if.req_din2[r*DIN_W +: DIN_W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (L + 2) @(negedge clk);
    endtask

    // Requester r alone, valid held: fill to the limit, then watch the retire/accept overlap.
    task automatic credit_run(input int r);
        logic [31:0] d1, prev_d1;
        logic        exp_rdy, prev_acc;
        int          exp_tot, n;
        n = 0;
        prev_acc = 1'b0;
        prev_d1 = '0;
        @(negedge clk);
        bus_if.req_valid = N_REQ'(1 << r);
        for (int rel = -1; rel <= L + 6; rel++) begin
            d1 = 32'h1000 * (r + 1) + n;
            set_op(r, d1, d1 + 3);
            #1;
            exp_rdy = (rel <= 2) || (rel >= L + 1 && rel <= L + 4);
            exp_tot = (rel == -1) ? 0 : (rel <= 2) ? rel + 1 : (rel <= L) ? 4 : (rel <= L + 4) ? 3 : 4;
            check($sformatf("credit%0d_ready_rel%0d", r, rel), bus_if.req_ready, exp_rdy ? (1 << r) : 0);
            check($sformatf("credit%0d_total_rel%0d", r, rel), bus_if.outstanding_total, exp_tot);
            check($sformatf("credit%0d_issue_rel%0d", r, rel), bus_if.core_din_valid, prev_acc);
            if (prev_acc) check($sformatf("credit%0d_din1_rel%0d", r, rel), bus_if.core_din1, prev_d1);
            if (exp_rdy) begin
                sb.push_back('{cyc: cyc + 2 + L, owner: N_REQ'(1 << r), dout: d1[15:0]});
                n++;
            end
            prev_acc = exp_rdy;
            prev_d1 = d1;
            @(negedge clk);
        end
        bus_if.req_valid = '0;
        repeat (2 * L + 8) @(negedge clk);
    endtask

    int c0, dv_base;

    initial begin
        bus_if.req_valid = '0;
        bus_if.req_din1  = '0;
        bus_if.req_din2  = '0;

        // Reset state, with every requester asserting valid
        repeat (2) @(negedge clk);
        bus_if.req_valid = '1;
        #1;
        check("rst_ready", bus_if.req_ready, 0);
        check("rst_issue", bus_if.core_din_valid, 0);
        check("rst_din1", bus_if.core_din1, 0);
        check("rst_resp_valid", bus_if.resp_valid, 0);
        check("rst_total", bus_if.outstanding_total, 0);
        check("rst_err", bus_if.err, 0);
        bus_if.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (L + 2) @(negedge clk);

        // Single request from requester 2
        set_op(2, 32'd100, 32'd100);
        bus_if.req_valid = 4'b0100;
        #1;
        check("single_ready", bus_if.req_ready, 4'b0100);
        sb.push_back('{cyc: cyc + 2 + L, owner: 4'b0100, dout: 16'h2000});
        @(negedge clk);
        bus_if.req_valid = '0;
        check("single_issue", bus_if.core_din_valid, 1);
        check("single_din1", bus_if.core_din1, 100);
        check("single_din2", bus_if.core_din2, 100);
        @(negedge clk);
        check("single_issue_once", bus_if.core_din_valid, 0);
        repeat (L + 5) @(negedge clk);
        check("single_err", bus_if.err, 0);
        check("single_total", bus_if.outstanding_total, 0);

        // Fairness from a fresh pointer: 0,1,2,3,0,...
        do_reset();
        for (int r = 0; r < N_REQ; r++) set_op(r, 32'h100 * (r + 1), 32'h100 * (r + 1) + 1);
        bus_if.req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("fair_grant%0d", k), bus_if.req_ready, 1 << (k % 4));
            sb.push_back('{cyc: cyc + 2 + L, owner: N_REQ'(1 << (k % 4)), dout: 16'(16'h100 * ((k % 4) + 1))});
            @(negedge clk);
        end
        bus_if.req_valid = '0;
        repeat (L + 6) @(negedge clk);

        // Credit limit, then simultaneous accept/retire keeping the count level
        credit_run(0);
        credit_run(1);

        // Core returns one cycle late: err at the expected slot, late result dropped
        late = 1'b1;
        @(negedge clk);
        set_op(3, 32'd5, 32'd7);
        bus_if.req_valid = 4'b1000;
        #1;
        check("misalign_ready", bus_if.req_ready, 4'b1000);
        c0 = cyc;
        @(negedge clk);
        bus_if.req_valid = '0;
        for (int w = 0; w < 100 && cyc < c0 + 1 + L; w++) @(negedge clk);
        check("misalign_err_before", bus_if.err, 0);
        @(negedge clk);
        check("misalign_err_rise", bus_if.err, 1);
        repeat (5) @(negedge clk);
        check("misalign_err_sticky", bus_if.err, 1);
        check("misalign_total", bus_if.outstanding_total, 0);
        late = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with three operations in flight; stale core results must be swallowed
        for (int k = 0; k < 3; k++) begin
            set_op(k, 32'h40 + k, 32'h80 + k);
            bus_if.req_valid = N_REQ'(1 << k);
            #1;
            check($sformatf("flight_ready%0d", k), bus_if.req_ready, 1 << k);
            @(negedge clk);
        end
        bus_if.req_valid = '0;
        repeat (3) @(negedge clk);
        check("flight_total", bus_if.outstanding_total, 3);
        rst = 1'b1;
        #1;
        check("flight_rst_total", bus_if.outstanding_total, 0);
        check("flight_rst_err", bus_if.err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dv_base = dv_count;
        repeat (L + 5) @(negedge clk);
        check("flight_stale_seen", dv_count - dv_base, 3);
        check("flight_err", bus_if.err, 0);
        check("flight_total_after", bus_if.outstanding_total, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
